// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time from the core,
// drives a single-outstanding data-memory request and writes load results
// back to the register file.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/req_ready operation handshake (ready only while idle)
//   req_is_store        1 = store, 0 = load
//   req_funct3          LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5
//   req_addr, req_wdata byte address, right-aligned store data
//   req_rd              load destination register
//   stall               core must hold its PC
//   mem_req ... mem_be  registered data-memory request
//   mem_ack, mem_rdata  data-memory response
//   rf_we/waddr/wdata   registered register-file write port
//   err                 one-cycle pulse: misaligned, illegal funct3 or timeout
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic [2:0]      op_funct3;
    logic [1:0]      op_off;
    logic [4:0]      op_rd;

    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_rep;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign req_ready = (state == StIdle);
    assign stall     = (state != StIdle) | (req_valid & req_ready);

    // Legality: unsigned variants exist only for loads; halfwords need
    // 2-byte alignment, words 4-byte alignment.
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'd0:    req_legal = 1'b1;
            3'd1:    req_legal = ~req_addr[0];
            3'd2:    req_legal = (req_addr[1:0] == 2'b00);
            3'd4:    req_legal = ~req_is_store;
            3'd5:    req_legal = ~req_is_store & ~req_addr[0];
            default: req_legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data so any lane sees its byte.
    always_comb begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_be        = 4'b0011 << req_addr[1:0];
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'b1111;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    // Right-align the addressed lane, then extend per access type.
    assign lane = mem_rdata >> {op_off, 3'b000};

    always_comb begin
        load_data = lane;
        case (op_funct3)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'b0, lane[7:0]};
            3'd5:    load_data = {16'b0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            op_funct3 <= 3'd0;
            op_off    <= 2'd0;
            op_rd     <= 5'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            err       <= 1'b0;
        end else begin
            err   <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            state     <= StReq;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata_rep;
                            op_funct3 <= req_funct3;
                            op_off    <= req_addr[1:0];
                            op_rd     <= req_rd;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    // Ack is tested first so it wins over a coinciding timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= StIdle;
                        end else begin
                            state    <= StWb;
                            rf_we    <= (op_rd != 5'd0);
                            rf_waddr <= op_rd;
                            rf_wdata <= load_data;
                        end
                    end else if (wait_cnt == CntLast) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        // Never passes CntLast, so it cannot wrap.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StWb: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned T = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;

    load_store_unit #(.ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .err          (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wdata;
        int unsigned cyc;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int unsigned cyc;
    } rf_exp_t;

    mem_exp_t    mem_q[$];
    rf_exp_t     rf_q[$];
    int unsigned err_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Reference model helpers, written from the access rules.
    function automatic int unsigned nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit f3_ok;
        f3_ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return f3_ok && ((a % nbytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int unsigned nb;
        logic [31:0] lane;
        logic [31:0] mask;
        logic [31:0] val;
        nb   = nbytes(f3);
        lane = rdata >> (8 * (a % 4));
        mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 1);
        val  = lane & mask;
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
        return val;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    logic     mem_req_prev = 1'b0;
    mem_exp_t cur;
    always @(negedge clk) begin
        chk("stall_rule", {31'd0, stall}, {31'd0, (~req_ready) | (req_valid & req_ready)});
        if (mem_req && !mem_req_prev) begin
            if (mem_q.size() == 0) begin
                unexpected("mem_req_rise");
            end else begin
                cur = mem_q.pop_front();
                chk("mem_req_cycle", cyc, cur.cyc);
                chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
                if (cur.chk_wdata) chk("mem_wdata", mem_wdata, cur.wdata);
            end
        end else if (mem_req) begin
            chk("mem_addr_stable", mem_addr, cur.addr);
            chk("mem_be_stable", {28'd0, mem_be}, {28'd0, cur.be});
            chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cur.we});
        end
        mem_req_prev = mem_req;
        if (rf_we) begin
            if (rf_q.size() == 0) begin
                unexpected("rf_we");
            end else begin
                rf_exp_t r;
                r = rf_q.pop_front();
                chk("rf_we_cycle", cyc, r.cyc);
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, r.waddr});
                chk("rf_wdata", rf_wdata, r.wdata);
            end
        end
        if (err) begin
            if (err_q.size() == 0) begin
                unexpected("err");
            end else begin
                int unsigned ec;
                ec = err_q.pop_front();
                chk("err_cycle", cyc, ec);
            end
        end
    end

    // Issues one operation. Called and returns just after a rising edge, DUT idle.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int unsigned ack_dly, input logic [31:0] rdata,
                         input bit no_ack);
        int unsigned n;
        int unsigned nb;
        bit          legal;
        mem_exp_t    m;
        rf_exp_t     r;
        chk("ready_before_op", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        n            = cyc;
        legal        = model_legal(st, f3, addr);
        nb           = nbytes(f3);
        if (!legal) begin
            err_q.push_back(n + 1);
        end else begin
            m.we        = st;
            m.addr      = addr & 32'hFFFF_FFFC;
            m.be        = 4'(((1 << nb) - 1) << (addr % 4));
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
            m.chk_wdata = st;
            m.cyc       = n + 1;
            mem_q.push_back(m);
            if (no_ack) begin
                err_q.push_back(n + 1 + T);
            end else if (!st && rd != 5'd0) begin
                r.waddr = rd;
                r.wdata = model_load(f3, addr, rdata);
                r.cyc   = n + 2 + ack_dly;
                rf_q.push_back(r);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (!legal) begin
            chk("ready_after_reject", {31'd0, req_ready}, 32'd1);
            @(posedge clk); #1;
            return;
        end
        if (no_ack) begin
            repeat (T - 1) begin @(posedge clk); #1; end
            chk("mem_req_last_wait", {31'd0, mem_req}, 32'd1);
            @(posedge clk); #1;
            chk("mem_req_after_timeout", {31'd0, mem_req}, 32'd0);
            chk("ready_after_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        repeat (ack_dly) begin @(posedge clk); #1; end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (st) begin
            chk("ready_after_store", {31'd0, req_ready}, 32'd1);
        end else begin
            chk("ready_in_wb", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            chk("ready_after_load", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [2:0] f3_pool [11] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    initial begin
        int unsigned n;
        mem_exp_t    m;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        reset = 1'b1;

        // First accept on the first edge after release.
        do_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF, 1'b0);
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 1, 32'h80AABBCC, 1'b0);
        do_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd8, 0, 32'h80AABBCC, 1'b0);
        do_op(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd3, 2, 32'h0, 1'b0);
        do_op(1'b0, 3'd2, 32'h101, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        do_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd0, 1, 32'h8001_7FFF, 1'b0);
        do_op(1'b0, 3'd2, 32'h400, 32'h0, 5'd6, 0, 32'h0, 1'b1);
        do_op(1'b0, 3'd5, 32'h402, 32'h0, 5'd9, 2, 32'hF00D_1234, 1'b0);

        // Reset while waiting for ack: transfer abandoned, late ack ignored.
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'd2;
        req_addr     = 32'h300;
        req_rd       = 5'd9;
        n            = cyc;
        m.we = 1'b0; m.addr = 32'h300; m.be = 4'hF; m.wdata = 32'h0; m.chk_wdata = 1'b0;
        m.cyc = n + 1;
        mem_q.push_back(m);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_mem_addr", mem_addr, 32'd0);
        chk("async_mem_be", {28'd0, mem_be}, 32'd0);
        chk("async_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("async_ready", {31'd0, req_ready}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        do_op(1'b0, 3'd2, 32'h500, 32'h0, 5'd10, 1, 32'h1357_9BDF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op(1'($urandom_range(0, 1)), f3_pool[$urandom_range(0, 10)], a, $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("rf_q_drained", rf_q.size(), 32'd0);
        chk("err_q_drained", err_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
